// File: rtl/int_priority_ctrl.sv
// int_priority_ctrl: multi-source interrupt controller for the 6502C core.
// It synchronises active-low request lines and latches the edge-type ones.
// It applies per-source enables and the global I-flag mask, then selects a
// winner by fixed priority (index 0 is the highest).
// The winner is handed to the control FSM through a take/done handshake,
// together with its vector address.
// Optional build macro INT_LOSTEDGE_EN adds the sticky `lost` output and the
// `lost_clr` input. These report edges that merged into a pending bit that
// was already set.
module int_priority_ctrl #(
  parameter int                 NUM_SRC   = 4,
  parameter int                 IDX_W     = 2,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = 4'b0011,
  parameter logic [NUM_SRC-1:0] NMI_MASK  = 4'b0011,
  parameter logic [15:0]        VEC_BASE  = 16'hFFF8
) (
  input  logic               fastClk,
  input  logic               RES_L,
  input  logic [NUM_SRC-1:0] src_l,
  input  logic [NUM_SRC-1:0] en,
  input  logic               mask_i,
  input  logic               take,
  input  logic               done,
  output logic               req,
  output logic [IDX_W-1:0]   active_idx,
  output logic [15:0]        vec_addr,
  output logic               in_service,
`ifdef INT_LOSTEDGE_EN
  output logic [NUM_SRC-1:0] lost,
  input  logic               lost_clr,
`endif
  output logic [NUM_SRC-1:0] pending
);

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t             state_reg;
  logic [NUM_SRC-1:0] s1_reg;
  logic [NUM_SRC-1:0] s2_reg;
  logic [NUM_SRC-1:0] prev_reg;
  logic [NUM_SRC-1:0] pending_reg;
  logic [NUM_SRC-1:0] pending_next;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] clr_grant;
  logic [NUM_SRC-1:0] elig;
  logic [IDX_W-1:0]   winner;
  logic [15:0]        win_vec;
  logic [IDX_W-1:0]   active_idx_reg;
  logic [15:0]        vec_addr_reg;
  logic               grant;

  // Per-source edge detect, eligibility and next pending value
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign edge_det[gi]  = EDGE_MASK[gi] & prev_reg[gi] & ~s2_reg[gi];
      assign clr_grant[gi] = grant & (winner == IDX_W'(gi));
      // Edge bits: a fresh edge beats a clearing grant in the same cycle.
      // Level bits: simply follow the synchronised line.
      assign pending_next[gi] = EDGE_MASK[gi]
                              ? (edge_det[gi] | (pending_reg[gi] & ~clr_grant[gi]))
                              : ~s2_reg[gi];
      assign elig[gi] = pending_reg[gi] & (NMI_MASK[gi] | (en[gi] & ~mask_i));
    end
  endgenerate

  // Fixed priority: lowest eligible index wins (scan high to low, last hit sticks)
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        winner = IDX_W'(i);
      end
    end
  end

  assign win_vec = VEC_BASE + (16'(winner) << 1);
  assign req     = (state_reg == IDLE) & (|elig);
  assign grant   = (state_reg == IDLE) & take & req;

  // Synchroniser chain and pending latch; flops idle high (inactive)
  always_ff @(posedge fastClk) begin
    if (!RES_L) begin
      s1_reg      <= '1;
      s2_reg      <= '1;
      prev_reg    <= '1;
      pending_reg <= '0;
    end else begin
      s1_reg      <= src_l;
      s2_reg      <= s1_reg;
      prev_reg    <= s2_reg;
      pending_reg <= pending_next;
    end
  end

  // Grant FSM: capture winner on take, hold it until done; reset drops a grant
  always_ff @(posedge fastClk) begin
    if (!RES_L) begin
      state_reg      <= IDLE;
      active_idx_reg <= '0;
      vec_addr_reg   <= VEC_BASE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            state_reg      <= SERVICE;
            active_idx_reg <= winner;
            vec_addr_reg   <= win_vec;
          end
        end
        SERVICE: begin
          // done has priority; take is ignored until IDLE is reached
          if (done) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign active_idx = active_idx_reg;
  assign vec_addr   = vec_addr_reg;
  assign in_service = (state_reg == SERVICE);
  assign pending    = pending_reg;

`ifdef INT_LOSTEDGE_EN
  logic [NUM_SRC-1:0] lost_reg;
  logic [NUM_SRC-1:0] lost_set;

  // An edge landing on an already-pending edge bit is a lost interrupt
  assign lost_set = edge_det & pending_reg & EDGE_MASK;

  // Sticky lost flags; a new loss beats a simultaneous clear
  always_ff @(posedge fastClk) begin
    if (!RES_L) begin
      lost_reg <= '0;
    end else begin
      lost_reg <= (lost_reg & ~{NUM_SRC{lost_clr}}) | lost_set;
    end
  end

  assign lost = lost_reg;
`endif

endmodule

// File: tb/tb_int_priority_ctrl.sv
// tb_int_priority_ctrl: directed-vector bench for int_priority_ctrl.
// Inputs change 1 time unit after a rising edge.
// Outputs are sampled at that same point.
module tb_int_priority_ctrl;

  logic       fastClk;
  logic       RES_L;
  logic [3:0] src_l;
  logic [3:0] en;
  logic       mask_i;
  logic       take;
  logic       done;
  logic       req;
  logic [1:0] active_idx;
  logic [15:0] vec_addr;
  logic       in_service;
  logic [3:0] pending;
`ifdef INT_LOSTEDGE_EN
  logic [3:0] lost;
  logic       lost_clr;
`endif

  int vectors;
  int miscompares;

  int_priority_ctrl dut (
    .fastClk    (fastClk),
    .RES_L      (RES_L),
    .src_l      (src_l),
    .en         (en),
    .mask_i     (mask_i),
    .take       (take),
    .done       (done),
    .req        (req),
    .active_idx (active_idx),
    .vec_addr   (vec_addr),
    .in_service (in_service),
`ifdef INT_LOSTEDGE_EN
    .lost       (lost),
    .lost_clr   (lost_clr),
`endif
    .pending    (pending)
  );

  initial fastClk = 1'b0;
  always #5 fastClk = ~fastClk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge fastClk);
      #1;
    end
  endtask

  task automatic do_reset();
    RES_L = 1'b0;
    src_l = 4'b1111;
    en = 4'b0000;
    mask_i = 1'b1;
    take = 1'b0;
    done = 1'b0;
`ifdef INT_LOSTEDGE_EN
    lost_clr = 1'b0;
`endif
    step(2);
    RES_L = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    RES_L = 1'b0;
    src_l = 4'b0000;
    en = 4'b0000;
    mask_i = 1'b1;
    take = 1'b0;
    done = 1'b0;
`ifdef INT_LOSTEDGE_EN
    lost_clr = 1'b0;
`endif
    step(2);
    vectors++;
    if (req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req got %0b expected 0", req);
    end
    vectors++;
    if (pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_pending got %b expected 0000", pending);
    end
    vectors++;
    if (vec_addr !== 16'hFFF8) begin
      miscompares++;
      $display("FAIL reset_vec got %h expected fff8", vec_addr);
    end
    vectors++;
    if (in_service !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_service got %0b expected 0", in_service);
    end
    vectors++;
    if (active_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_idx got %0d expected 0", active_idx);
    end
`ifdef INT_LOSTEDGE_EN
    vectors++;
    if (lost !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_lost got %b expected 0000", lost);
    end
`endif
    RES_L = 1'b1;
    step(2);
    vectors++;
    if (pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL latency_edge2_pending got %b expected 0000", pending);
    end
    step(1);
    vectors++;
    if (pending !== 4'b1111) begin
      miscompares++;
      $display("FAIL latency_edge3_pending got %b expected 1111", pending);
    end
    vectors++;
    if (req !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_edge3_req got %0b expected 1", req);
    end
    $display("test_reset complete");
  endtask

  task automatic test_edge_latch();
    do_reset();
    en = 4'b0000;
    mask_i = 1'b1;
    src_l = 4'b1101;
    step(1);
    src_l = 4'b1111;
    step(1);
    vectors++;
    if (pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL edge_early_pending got %b expected 0000", pending);
    end
    step(1);
    vectors++;
    if (pending !== 4'b0010) begin
      miscompares++;
      $display("FAIL edge_pending got %b expected 0010", pending);
    end
    vectors++;
    if (req !== 1'b1) begin
      miscompares++;
      $display("FAIL edge_req got %0b expected 1", req);
    end
    step(2);
    vectors++;
    if (pending !== 4'b0010) begin
      miscompares++;
      $display("FAIL edge_held got %b expected 0010", pending);
    end
    take = 1'b1;
    step(1);
    take = 1'b0;
    vectors++;
    if (active_idx !== 2'd1) begin
      miscompares++;
      $display("FAIL edge_grant_idx got %0d expected 1", active_idx);
    end
    vectors++;
    if (vec_addr !== 16'hFFFA) begin
      miscompares++;
      $display("FAIL edge_grant_vec got %h expected fffa", vec_addr);
    end
    vectors++;
    if (pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL edge_grant_pending got %b expected 0000", pending);
    end
    vectors++;
    if (in_service !== 1'b1) begin
      miscompares++;
      $display("FAIL edge_grant_in_service got %0b expected 1", in_service);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    vectors++;
    if (in_service !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_done_in_service got %0b expected 0", in_service);
    end
    vectors++;
    if (req !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_done_req got %0b expected 0", req);
    end
    vectors++;
    if (vec_addr !== 16'hFFFA) begin
      miscompares++;
      $display("FAIL edge_idle_hold_vec got %h expected fffa", vec_addr);
    end
    $display("test_edge_latch complete");
  endtask

  task automatic test_priority_mask();
    do_reset();
    en = 4'b1100;
    mask_i = 1'b1;
    src_l = 4'b0011;
    step(3);
    vectors++;
    if (pending !== 4'b1100) begin
      miscompares++;
      $display("FAIL prio_pending got %b expected 1100", pending);
    end
    vectors++;
    if (req !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_masked_req got %0b expected 0", req);
    end
    mask_i = 1'b0;
    #1;
    vectors++;
    if (req !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_unmasked_req got %0b expected 1", req);
    end
    en = 4'b0000;
    #1;
    vectors++;
    if (req !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_disabled_req got %0b expected 0", req);
    end
    en = 4'b1100;
    take = 1'b1;
    step(1);
    take = 1'b0;
    vectors++;
    if (active_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL prio_grant_idx got %0d expected 2", active_idx);
    end
    vectors++;
    if (vec_addr !== 16'hFFFC) begin
      miscompares++;
      $display("FAIL prio_grant_vec got %h expected fffc", vec_addr);
    end
    vectors++;
    if (req !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_service_req got %0b expected 0", req);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    vectors++;
    if (pending !== 4'b1100) begin
      miscompares++;
      $display("FAIL prio_level_pending got %b expected 1100", pending);
    end
    vectors++;
    if (req !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_level_req got %0b expected 1", req);
    end
    // only source 3 enabled -> it wins with vector FFFE
    en = 4'b1000;
    take = 1'b1;
    step(1);
    take = 1'b0;
    vectors++;
    if (vec_addr !== 16'hFFFE || active_idx !== 2'd3) begin
      miscompares++;
      $display("FAIL prio_src3_grant got idx %0d vec %h expected idx 3 vec fffe", active_idx, vec_addr);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    $display("test_priority_mask complete");
  endtask

  task automatic test_simultaneous();
    do_reset();
    en = 4'b1100;
    mask_i = 1'b0;
    src_l = 4'b1011;
    step(3);
    take = 1'b1;
    step(1);
    vectors++;
    if (in_service !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_first_grant got %0b expected 1", in_service);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    vectors++;
    if (in_service !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_done_take_in_service got %0b expected 0", in_service);
    end
    step(1);
    take = 1'b0;
    vectors++;
    if (in_service !== 1'b1 || active_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL sim_regrant got in_service %0b idx %0d expected 1 2", in_service, active_idx);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    src_l = 4'b1111;
    // done while idle is ignored
    done = 1'b1;
    step(1);
    done = 1'b0;
    vectors++;
    if (in_service !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_idle_done got %0b expected 0", in_service);
    end

    // edge on source 0 coinciding with its grant
    do_reset();
    src_l = 4'b1110;
    step(1);
    src_l = 4'b1111;
    step(2);
    vectors++;
    if (pending !== 4'b0001) begin
      miscompares++;
      $display("FAIL sim_src0_pending got %b expected 0001", pending);
    end
    src_l = 4'b1110;
    step(1);
    src_l = 4'b1111;
    step(1);
    take = 1'b1;
    step(1);
    take = 1'b0;
    vectors++;
    if (in_service !== 1'b1 || active_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL sim_src0_grant got in_service %0b idx %0d expected 1 0", in_service, active_idx);
    end
    vectors++;
    if (pending !== 4'b0001) begin
      miscompares++;
      $display("FAIL sim_edge_vs_grant got %b expected 0001", pending);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    $display("test_simultaneous complete");
  endtask

  task automatic test_reset_mid_service();
    do_reset();
    src_l = 4'b1101;
    step(1);
    src_l = 4'b1111;
    step(2);
    take = 1'b1;
    step(1);
    take = 1'b0;
    vectors++;
    if (in_service !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_grant got %0b expected 1", in_service);
    end
    RES_L = 1'b0;
    step(1);
    RES_L = 1'b1;
    vectors++;
    if (in_service !== 1'b0 || pending !== 4'b0000 || req !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got in_service %0b pending %b req %0b expected 0 0000 0", in_service, pending, req);
    end
    vectors++;
    if (vec_addr !== 16'hFFF8 || active_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL mid_reset_vec got %h idx %0d expected fff8 0", vec_addr, active_idx);
    end
    $display("test_reset_mid_service complete");
  endtask

  task automatic test_merge_lost();
    int grants;
    do_reset();
    // three one-cycle pulses on source 0
    for (int p = 0; p < 3; p++) begin
      src_l = 4'b1110;
      step(1);
      src_l = 4'b1111;
      step(1);
    end
    step(3);
    vectors++;
    if (pending !== 4'b0001) begin
      miscompares++;
      $display("FAIL merge_pending got %b expected 0001", pending);
    end
`ifdef INT_LOSTEDGE_EN
    vectors++;
    if (lost !== 4'b0001) begin
      miscompares++;
      $display("FAIL lost_set got %b expected 0001", lost);
    end
`endif
    grants = 0;
    for (int r = 0; r < 3; r++) begin
      if (req === 1'b1) begin
        grants++;
        take = 1'b1;
        step(1);
        take = 1'b0;
        done = 1'b1;
        step(1);
        done = 1'b0;
      end else begin
        step(1);
      end
    end
    vectors++;
    if (grants !== 1) begin
      miscompares++;
      $display("FAIL merge_grants got %0d expected 1", grants);
    end
`ifdef INT_LOSTEDGE_EN
    vectors++;
    if (lost !== 4'b0001) begin
      miscompares++;
      $display("FAIL lost_sticky got %b expected 0001", lost);
    end
    lost_clr = 1'b1;
    step(1);
    lost_clr = 1'b0;
    vectors++;
    if (lost !== 4'b0000) begin
      miscompares++;
      $display("FAIL lost_clr got %b expected 0000", lost);
    end
`endif
    $display("test_merge_lost complete");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_edge_latch();
    test_priority_mask();
    test_simultaneous();
    test_reset_mid_service();
    test_merge_lost();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
